// File: rtl/xain_apf_video.sv
// Xain'd Sleena core video to Analogue Pocket APF video bus formatter.
// Optional alternate-line darkening is compiled in with `define XAIN_SCANLINE_EN.
module xain_apf_video #(
  parameter bit HS_ACTIVE_HIGH = 1'b0,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pixel,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  sl_mode,
  output logic [23:0] vid_rgb,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic [9:0]  h_active,
  output logic [8:0]  v_active
);

  logic       hs_prev, vs_prev, de_prev;
  logic       armed, hs_pend, line_odd;
  logic [9:0] pix_cnt;
  logic [8:0] line_cnt;

  logic hs_n, vs_n, hs_rise, vs_rise, de_next, de_fall, gate, hs_req;
  logic [23:0] rgb_mod;

  assign hs_n    = HS_ACTIVE_HIGH ? hsync_in : ~hsync_in;
  assign vs_n    = VS_ACTIVE_HIGH ? vsync_in : ~vsync_in;
  assign hs_rise = hs_n & ~hs_prev;
  assign vs_rise = vs_n & ~vs_prev;
  assign de_next = ~hblank_in & ~vblank_in;
  assign de_fall = de_prev & ~de_next;
  // The arming VS edge is itself emitted, so a frame starts with its VS pulse.
  assign gate    = armed | vs_rise;
  assign hs_req  = hs_rise | hs_pend;

`ifdef XAIN_SCANLINE_EN
  function automatic logic [7:0] shade(input logic [7:0] c, input logic [1:0] k);
    logic [9:0] p, d;
    p = {2'b00, c} * {8'h00, k};
    d = {2'b00, c} - (p >> 2);
    return d[7:0];
  endfunction

  logic dark;
  assign dark    = line_odd & (sl_mode != 2'b00);
  assign rgb_mod = dark ? {shade(r_in, sl_mode), shade(g_in, sl_mode), shade(b_in, sl_mode)}
                        : {r_in, g_in, b_in};
`else
  logic unused_sl;
  assign unused_sl = ^sl_mode;
  assign rgb_mod   = {r_in, g_in, b_in};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      de_prev  <= 1'b0;
      armed    <= 1'b0;
      hs_pend  <= 1'b0;
      line_odd <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      h_active <= '0;
      v_active <= '0;
      vid_rgb  <= '0;
      vid_de   <= 1'b0;
      vid_hs   <= 1'b0;
      vid_vs   <= 1'b0;
    end else if (ce_pixel) begin
      hs_prev <= hs_n;
      vs_prev <= vs_n;
      de_prev <= de_next;
      if (vs_rise) armed <= 1'b1;

      // VS wins a tie; HS is pushed one pixel later and merges with any new edge.
      vid_vs  <= gate & vs_rise;
      vid_hs  <= gate & hs_req & ~vs_rise;
      hs_pend <= gate & hs_req & vs_rise;
      vid_de  <= gate & de_next;
      vid_rgb <= (gate & de_next) ? rgb_mod : 24'h0;

      // pix_cnt indexes the current DE pixel, so +1 on the falling edge is the width.
      if (hs_rise)
        pix_cnt <= '0;
      else if (de_next && de_prev && pix_cnt != 10'h3ff)
        pix_cnt <= pix_cnt + 10'd1;
      if (de_fall)
        h_active <= (pix_cnt == 10'h3ff) ? pix_cnt : pix_cnt + 10'd1;

      if (vs_rise) begin
        v_active <= line_cnt;
        line_cnt <= '0;
        line_odd <= 1'b0;
      end else if (de_fall) begin
        if (line_cnt != 9'h1ff) line_cnt <= line_cnt + 9'd1;
        line_odd <= ~line_odd;
      end
    end
  end

endmodule

// File: tb/tb_xain_apf_video.sv
// Directed scoreboard bench for xain_apf_video; scanline expectations follow `XAIN_SCANLINE_EN.
module tb_xain_apf_video;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_pixel;
  logic [7:0]  r_in, g_in, b_in;
  logic        hblank_in, vblank_in, hsync_in, vsync_in;
  logic [1:0]  sl_mode;
  logic [23:0] vid_rgb;
  logic        vid_de, vid_hs, vid_vs;
  logic [9:0]  h_active;
  logic [8:0]  v_active;

  int   checks = 0;
  int   failures = 0;
  bit   armed = 0;
  exp_t sb[$];

  xain_apf_video #(.HS_ACTIVE_HIGH(1'b0), .VS_ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .sl_mode(sl_mode),
    .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .h_active(h_active), .v_active(v_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ch_shade(input logic [7:0] c, input logic [1:0] k);
    int v;
    v = int'(c) - (int'(c) * int'(k)) / 4;
    return v[7:0];
  endfunction

  function automatic logic [23:0] shade(input logic [23:0] c, input logic [1:0] k, input bit odd);
`ifdef XAIN_SCANLINE_EN
    if (odd && k != 2'b00)
      return {ch_shade(c[23:16], k), ch_shade(c[15:8], k), ch_shade(c[7:0], k)};
`endif
    return c;
  endfunction

  // One pixel: strobe on the next edge, check 1 clk later, re-check just before the next strobe.
  task automatic strobe(input logic [23:0] col, input logic hb, input logic vb,
                        input logic hs, input logic vs, input logic [1:0] mode, input exp_t e);
    exp_t got, want;
    {r_in, g_in, b_in} = col;
    hblank_in = hb;
    vblank_in = vb;
    hsync_in  = ~hs;
    vsync_in  = vs;
    sl_mode   = mode;
    ce_pixel  = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 ce_pixel = 1'b0;
    want = sb.pop_front();
    got = {vid_rgb, vid_de, vid_hs, vid_vs};
    chk("pix", 32'(got), 32'(want));
    repeat (3) @(posedge clk);
    #1 got = {vid_rgb, vid_de, vid_hs, vid_vs};
    chk("hold", 32'(got), 32'(want));
  endtask

  // Frame geometry: w_tot = w+16, HS on x<4, VS on y<2, DE at x in [8,8+w), y in [vb,vb+la).
  task automatic run_frame(input int w, input int la, input int vb, input int start_i,
                           input int stop_i, input logic [23:0] col, input logic [1:0] mode,
                           input int exp_v, input int exp_h, input int freeze_i);
    int wt, x, y;
    logic hsn, vsn, hbl, vbl;
    exp_t e, got;
    wt = w + 16;
    for (int i = start_i; i < stop_i; i++) begin
      y = i / wt;
      x = i % wt;
      hsn = (x < 4);
      vsn = (y < 2);
      hbl = !(x >= 8 && x < 8 + w);
      vbl = !(y >= vb && y < vb + la);
      if (y == 0 && x == 0) armed = 1;
      e.vs  = armed && y == 0 && x == 0;
      e.hs  = armed && ((x == 0 && y != 0) || (x == 1 && y == 0));
      e.de  = armed && !hbl && !vbl;
      e.rgb = e.de ? shade(col, mode, ((y - vb) % 2) == 1) : 24'h0;
      strobe(col, hbl, vbl, hsn, vsn, mode, e);
      if (y == 0 && x == 0 && exp_v >= 0) chk("v_active", 32'(v_active), exp_v);
      if (i == freeze_i) begin
        {r_in, g_in, b_in} = 24'($urandom);
        hsync_in  = ~hsync_in;
        vsync_in  = ~vsync_in;
        hblank_in = ~hblank_in;
        repeat (1000) @(posedge clk);
        #1 got = {vid_rgb, vid_de, vid_hs, vid_vs};
        chk("freeze", 32'(got), 32'(e));
      end
    end
    if (exp_h >= 0) chk("h_active", 32'(h_active), exp_h);
  endtask

  initial begin
    reset_n = 1'b0;
    ce_pixel = 1'b0;
    {r_in, g_in, b_in} = 24'h0;
    hblank_in = 1'b1; vblank_in = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b0;
    sl_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1 chk("rst_out", 32'({vid_rgb, vid_de, vid_hs, vid_vs}), 32'h0);
    chk("rst_meas", 32'({h_active, v_active}), 32'h0);
    reset_n = 1'b1;

    // Tail of a frame before any VS: nothing may come out.
    run_frame(4, 224, 16, 250 * 20, 256 * 20, 24'hFF8010, 2'b00, -1, -1, -1);
    // Frame 1 arms; frame 2 reports its size, then reset hits at line 100 with DE high.
    run_frame(4, 224, 16, 0, 256 * 20, 24'hFF8010, 2'b00, 0, 4, -1);
    run_frame(4, 224, 16, 0, 100 * 20 + 10, 24'hFF8010, 2'b00, 224, 4, -1);
    chk("pre_rst_de", 32'(vid_de), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_rst_out", 32'({vid_rgb, vid_de, vid_hs, vid_vs}), 32'h0);
    chk("async_rst_meas", 32'({h_active, v_active}), 32'h0);
    armed = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    // Rest of the interrupted frame stays dark until the next VS.
    run_frame(4, 224, 16, 100 * 20 + 10, 256 * 20, 24'hFF8010, 2'b00, -1, 4, -1);
    // 384-wide lines with a long ce_pixel stall mid-line.
    run_frame(384, 2, 2, 0, 4 * 400, 24'hFF8010, 2'b00, -1, 384, 2 * 400 + 100);
    // Scanline frames.
    run_frame(4, 4, 2, 0, 8 * 20, 24'hFFFFFF, 2'b10, 2, 4, -1);
    run_frame(4, 4, 2, 0, 8 * 20, 24'hFF8010, 2'b11, 4, 4, -1);
    run_frame(4, 4, 2, 0, 8 * 20, 24'h408020, 2'b01, 4, 4, -1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
